fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- IF stage of the ARM pipeline: owns the PC, drives the byte address into the instruction memory and captures the returned word.
- Registers the fetched word with its PC+4 into the IF/ID pipeline register that feeds decode.
- Handles hazard freeze and branch redirect/flush coming from the hazard unit and the EX stage.

Parameters:
- ADDR_W, 32, PC / address width in bits.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'hE000_0000, bubble word inserted on flush/reset (AND R0,R0,R0, cond AL).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- freeze  in  1  hazard stall; hold PC and IF/ID contents.
- branch_taken  in  1  EX-stage redirect; also flushes IF/ID.
- branch_addr  in  ADDR_W  redirect target (byte address).
- inst_addr  out  ADDR_W  byte address to instruction memory (= pc).
- inst_data  in  32  big-endian word returned combinationally by instruction memory.
- if_id_pc  out  ADDR_W  PC+4 of the captured instruction.
- if_id_instr  out  32  captured instruction.
- if_id_valid  out  1  IF/ID holds a real instruction (0 = bubble).

Behaviour:
- Reset (rst=0, async, takes effect immediately, also mid-operation): pc=RESET_PC, if_id_pc=0, if_id_instr=NOP_INSTR, if_id_valid=0. All three IF/ID outputs stay at these values until the first enabled rising edge after rst deasserts.
- inst_addr = pc, combinational. Memory read latency is zero: inst_data is sampled at the same edge that advances pc.
- Next-PC priority per rising edge:
  - branch_taken: pc <= {branch_addr[ADDR_W-1:2],2'b00}. The low two bits are always forced to zero.
  - else freeze: pc holds.
  - else pc <= pc+4, modulo 2^ADDR_W. At pc=32'hFFFF_FFFC the PC wraps to 0 with no flag.
- IF/ID register, same edge, same priority:
  - branch_taken: flush. if_id_valid<=0, if_id_instr<=NOP_INSTR, if_id_pc<=0.
  - else freeze: all IF/ID fields hold.
  - else load. if_id_instr<=inst_data, if_id_pc<=pc+4, if_id_valid<=1.
- branch_taken and freeze both high: branch wins. The PC redirects and IF/ID flushes; freeze is ignored for that cycle.
- Back-to-back branch_taken on consecutive cycles: each redirects. Only the last target survives; IF/ID stays a bubble throughout.
- Latency: an instruction at address A appears on if_id_instr one edge after inst_addr=A, given no freeze or branch.
- Branch penalty: the instruction fetched in the redirect cycle is discarded. The target instruction enters IF/ID on the edge after the redirect edge.
- The block holds no other state. No X may propagate from if_id_* after reset, independent of inst_data.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_fetched (32) and perf_bubbles (32), both reset to 0 by rst.
  - perf_fetched increments on each IF/ID load edge.
  - perf_bubbles increments on each flush edge and each freeze edge.
  - Both counters saturate at 32'hFFFF_FFFF.
- Undefined: the ports and counters do not exist. Functional behaviour of all other outputs is identical in both builds.

Decomposition:
- Shared package/defines: ADDR_W default, RESET_PC, NOP_INSTR constant, and the word increment constant (4).
- Sub-module pc_reg: async active-low reset, load-enable register with reset value parameter. Instantiated for pc.
- IF/ID register and next-PC mux stay in fetch_stage.

Test Plan:
- Reset release, no freeze/branch, memory returns addr-based words: inst_addr 0,4,8,12 on successive edges; if_id_pc 4,8,12 one cycle behind; if_id_valid rises on the first edge.
- freeze=1 for 3 cycles with pc=16: inst_addr stays 16; if_id_instr/pc unchanged. After release, pc=20 on the next edge.
- branch_taken=1, branch_addr=0x94 at pc=0x9C: next edge pc=0x94, if_id_valid=0, if_id_instr=0xE0000000. Following edge captures word at 0x94 with if_id_pc=0x98.
- branch_taken and freeze together, branch_addr=0x27: pc becomes 0x24, IF/ID flushed.
- pc preset near top (RESET_PC=32'hFFFF_FFF8): sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- rst pulsed low mid-stream at an asynchronous instant: outputs go to reset values before the next clk edge. FETCH_PERF_CNT_EN build: counters read 0 after reset, then match the counted loads/bubbles.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared constants for the IF stage (address width, reset PC, bubble word, PC step).
package fetch_stage_pkg;
  localparam int          ADDR_W_DEF    = 32;
  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'hE000_0000;
  localparam int          WORD_INC      = 4;
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: hazard, instruction-memory and IF/ID signals of the fetch stage; perf ports under FETCH_PERF_CNT_EN.
interface fetch_stage_if #(parameter int ADDR_W = 32);
  logic              freeze;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_addr;
  logic [ADDR_W-1:0] inst_addr;
  logic [31:0]       inst_data;
  logic [ADDR_W-1:0] if_id_pc;
  logic [31:0]       if_id_instr;
  logic              if_id_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]       perf_fetched;
  logic [31:0]       perf_bubbles;
  modport master (input freeze, branch_taken, branch_addr, inst_data,
                  output inst_addr, if_id_pc, if_id_instr, if_id_valid, perf_fetched, perf_bubbles);
  modport slave  (output freeze, branch_taken, branch_addr, inst_data,
                  input inst_addr, if_id_pc, if_id_instr, if_id_valid, perf_fetched, perf_bubbles);
`else
  modport master (input freeze, branch_taken, branch_addr, inst_data,
                  output inst_addr, if_id_pc, if_id_instr, if_id_valid);
  modport slave  (output freeze, branch_taken, branch_addr, inst_data,
                  input inst_addr, if_id_pc, if_id_instr, if_id_valid);
`endif
endinterface

// File: rtl/fetch_stage_pc_reg.sv
// pc_reg: load-enable register with asynchronous active-low reset to RST_VAL.
module pc_reg #(
  parameter int             W       = 32,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) q_o <= RST_VAL;
    else if (en_i) q_o <= d_i;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: ARM IF stage with PC, next-PC mux and IF/ID register; FETCH_PERF_CNT_EN adds fetch/bubble counters.
module fetch_stage import fetch_stage_pkg::*; #(
  parameter int                ADDR_W    = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(RESET_PC_DEF),
  parameter logic [31:0]       NOP_INSTR = NOP_INSTR_DEF
) (
  input logic           clk,
  input logic           rst,
  fetch_stage_if.master bus
);
  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc;
  logic              pc_en;
  logic [ADDR_W-1:0] if_id_pc_q, if_id_pc_d;
  logic [31:0]       if_id_instr_q, if_id_instr_d;
  logic              if_id_valid_q, if_id_valid_d;
  assign pc_inc = pc_q + ADDR_W'(WORD_INC);
  // branch outranks freeze for both the PC and the IF/ID register
  always_comb begin
    pc_en         = bus.branch_taken | ~bus.freeze;
    pc_d          = bus.branch_taken ? {bus.branch_addr[ADDR_W-1:2], 2'b00} : pc_inc;
    if_id_pc_d    = bus.branch_taken ? '0 : bus.freeze ? if_id_pc_q : pc_inc;
    if_id_instr_d = bus.branch_taken ? NOP_INSTR : bus.freeze ? if_id_instr_q : bus.inst_data;
    if_id_valid_d = bus.branch_taken ? 1'b0 : bus.freeze ? if_id_valid_q : 1'b1;
  end
  pc_reg #(.W(ADDR_W), .RST_VAL(RESET_PC)) u_pc (
    .clk(clk), .rst(rst), .en_i(pc_en), .d_i(pc_d), .q_o(pc_q)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      if_id_pc_q    <= '0;
      if_id_instr_q <= NOP_INSTR;
      if_id_valid_q <= 1'b0;
    end else begin
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_valid_q <= if_id_valid_d;
    end
  assign bus.inst_addr   = pc_q;
  assign bus.if_id_pc    = if_id_pc_q;
  assign bus.if_id_instr = if_id_instr_q;
  assign bus.if_id_valid = if_id_valid_q;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d, perf_bubbles_q, perf_bubbles_d;
  always_comb begin
    perf_fetched_d = (!bus.branch_taken && !bus.freeze && perf_fetched_q != '1) ? perf_fetched_q + 32'd1 : perf_fetched_q;
    perf_bubbles_d = ((bus.branch_taken || bus.freeze) && perf_bubbles_q != '1) ? perf_bubbles_q + 32'd1 : perf_bubbles_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      perf_fetched_q <= '0;
      perf_bubbles_q <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_bubbles_q <= perf_bubbles_d;
    end
  assign bus.perf_fetched = perf_fetched_q;
  assign bus.perf_bubbles = perf_bubbles_q;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage; perf counters checked when FETCH_PERF_CNT_EN is defined.
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'hE000_0000;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rst2 = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  fetch_stage_if #(.ADDR_W(32)) bus ();
  fetch_stage_if #(.ADDR_W(32)) bus2 ();
  fetch_stage dut (.clk(clk), .rst(rst), .bus(bus));
  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_top (.clk(clk), .rst(rst2), .bus(bus2));
  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction
  assign bus.inst_data  = mem(bus.inst_addr);
  assign bus2.inst_data = mem(bus2.inst_addr);
  typedef struct packed {
    logic [31:0] pc, ipc, ins;
    logic        v;
    logic [31:0] pf, pb;
  } exp_t;
  exp_t sb[$];
  logic [31:0] m_pc, m_ipc, m_ins, m_pf, m_pb;
  logic        m_v;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    m_pc = 32'h0; m_ipc = 32'h0; m_ins = NOP; m_v = 1'b0; m_pf = 0; m_pb = 0;
  endtask
  task automatic check_perf(input logic [31:0] pf, input logic [31:0] pb);
`ifdef FETCH_PERF_CNT_EN
    check("perf_fetched", bus.perf_fetched, pf);
    check("perf_bubbles", bus.perf_bubbles, pb);
`else
    if (pf === 32'hx || pb === 32'hx) $display("perf model undefined");
`endif
  endtask
  task automatic step(input logic fr, input logic br, input logic [31:0] ba);
    exp_t e;
    bus.freeze = fr; bus.branch_taken = br; bus.branch_addr = ba;
    e.pc  = br ? {ba[31:2], 2'b00} : fr ? m_pc : m_pc + 32'd4;
    e.ipc = br ? 32'h0 : fr ? m_ipc : m_pc + 32'd4;
    e.ins = br ? NOP : fr ? m_ins : mem(m_pc);
    e.v   = br ? 1'b0 : fr ? m_v : 1'b1;
    e.pf  = (!br && !fr) ? m_pf + 1 : m_pf;
    e.pb  = (br || fr) ? m_pb + 1 : m_pb;
    m_pc = e.pc; m_ipc = e.ipc; m_ins = e.ins; m_v = e.v; m_pf = e.pf; m_pb = e.pb;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("inst_addr", bus.inst_addr, e.pc);
    check("if_id_pc", bus.if_id_pc, e.ipc);
    check("if_id_instr", bus.if_id_instr, e.ins);
    check("if_id_valid", {31'b0, bus.if_id_valid}, {31'b0, e.v});
    check_perf(e.pf, e.pb);
    @(negedge clk);
  endtask
  task automatic check_reset_outputs();
    check("rst_inst_addr", bus.inst_addr, 32'h0);
    check("rst_if_id_pc", bus.if_id_pc, 32'h0);
    check("rst_if_id_instr", bus.if_id_instr, NOP);
    check("rst_if_id_valid", {31'b0, bus.if_id_valid}, 32'h0);
    check_perf(32'h0, 32'h0);
  endtask
  initial begin
    bus.freeze = 1'b0; bus.branch_taken = 1'b0; bus.branch_addr = '0;
    bus2.freeze = 1'b0; bus2.branch_taken = 1'b0; bus2.branch_addr = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs();
    check("top_rst_pc", bus2.inst_addr, 32'hFFFF_FFF8);
    rst2 = 1'b1;
    @(posedge clk); #1;
    check("top_pc_fffc", bus2.inst_addr, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    check("top_pc_wrap", bus2.inst_addr, 32'h0);
    check("top_ipc_wrap", bus2.if_id_pc, 32'h0);
    check("top_valid", {31'b0, bus2.if_id_valid}, 32'h1);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0);
    check("pc_16", bus.inst_addr, 32'd16);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 34; i++) step(1'b0, 1'b0, 32'h0);
    check("pc_9c", bus.inst_addr, 32'h9C);
    step(1'b0, 1'b1, 32'h94);
    step(1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h27);
    step(1'b0, 1'b1, 32'h100);
    step(1'b0, 1'b1, 32'h203);
    step(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 40; i++)
      step(($urandom_range(3) == 0), ($urandom_range(5) == 0), $urandom);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    model_reset();
    check_reset_outputs();
    @(negedge clk);
    check_reset_outputs();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h40);
    step(1'b0, 1'b0, 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
